// File: rtl/display_timing_gen.sv
// display_timing_gen
//   Raster timing generator: walks an (x, y) position across a frame of
//   H_TOTAL x V_TOTAL pixel slots, producing syncs, an active-video flag,
//   a frame-start pulse and a divided sprite-refresh tick.
//
// Ports
//   i_clk             clock, all logic on rising edge
//   i_rst_n           asynchronous active-low reset
//   i_pix_stb         pixel clock-enable; position advances only when high
//   o_x, o_y          current horizontal / vertical count (16 bits, unsigned)
//   o_h_sync/o_v_sync syncs, asserted at level SYNC_POL
//   o_active          high inside the visible H_ACTIVE x V_ACTIVE window
//   o_frame_start     one-cycle pulse when the position wraps to (0,0)
//   o_sprite_refresh  one-cycle pulse every REFRESH_DIV frame starts
//   o_frame_cnt       frame index within the refresh period
//
// Build option
//   REFRESH_DIVIDER_EN  when defined, the frame divider is built; otherwise
//                       o_sprite_refresh mirrors o_frame_start and
//                       o_frame_cnt reads 0.
module display_timing_gen #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned H_FP        = 40,
    parameter int unsigned H_SYNC      = 128,
    parameter int unsigned H_BP        = 88,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned V_FP        = 1,
    parameter int unsigned V_SYNC      = 4,
    parameter int unsigned V_BP        = 23,
    parameter bit          SYNC_POL    = 1'b1,
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_active,
    output logic        o_frame_start,
    output logic        o_sprite_refresh,
    output logic [7:0]  o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SYNC_B = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_E = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_SYNC_B = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_E = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);

    if (REFRESH_DIV < 1 || REFRESH_DIV > 255) begin : g_div_check
        $error("REFRESH_DIV must be in 1..255");
    end

    logic [15:0] x_q, y_q, x_d, y_d;
    logic        h_sync_q, v_sync_q, active_q, frame_start_q;
    logic        h_sync_d, v_sync_d, active_d;
    logic        h_wrap, v_wrap, frame_wrap;

    always_comb begin
        h_wrap     = (x_q == H_LAST);
        v_wrap     = (y_q == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        x_d        = h_wrap ? 16'd0 : x_q + 16'd1;
        y_d        = y_q;
        if (h_wrap) begin
            y_d = v_wrap ? 16'd0 : y_q + 16'd1;
        end
        // Decode from the next position so flags line up with o_x/o_y.
        h_sync_d = ((x_d >= H_SYNC_B) && (x_d < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        v_sync_d = ((y_d >= V_SYNC_B) && (y_d < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        active_d = (x_d < H_ACT) && (y_d < V_ACT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (i_pix_stb) begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            active_q      <= active_d;
            frame_start_q <= frame_wrap;
        end else begin
            frame_start_q <= 1'b0;
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_h_sync      = h_sync_q;
    assign o_v_sync      = v_sync_q;
    assign o_active      = active_q;
    assign o_frame_start = frame_start_q;

`ifdef REFRESH_DIVIDER_EN
    localparam logic [7:0] CNT_LAST = 8'(REFRESH_DIV - 1);

    logic [7:0] frame_cnt_q;
    logic       refresh_q;

    // Counter and refresh update on the same edge that raises o_frame_start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
            refresh_q   <= 1'b0;
        end else if (i_pix_stb && frame_wrap) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_q <= '0;
                refresh_q   <= 1'b1;
            end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                refresh_q   <= 1'b0;
            end
        end else begin
            refresh_q <= 1'b0;
        end
    end

    assign o_frame_cnt      = frame_cnt_q;
    assign o_sprite_refresh = refresh_q;
`else
    assign o_frame_cnt      = '0;
    assign o_sprite_refresh = frame_start_q;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
module tb_display_timing_gen;

    // Small raster so whole frames fit in a short run.
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 15
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int NS = HT * VT;             // 120
    localparam int DHT = 1056, DVT = 628;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stb = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_hs, a_vs, a_act, a_fs, a_rf;
    logic        b_hs, b_vs, b_act, b_fs, b_rf;
    logic        c_hs, c_vs, c_act, c_fs, c_rf;
    logic [7:0]  a_fc, b_fc, c_fc;

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .REFRESH_DIV(4)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb),
        .o_x(a_x), .o_y(a_y), .o_h_sync(a_hs), .o_v_sync(a_vs), .o_active(a_act),
        .o_frame_start(a_fs), .o_sprite_refresh(a_rf), .o_frame_cnt(a_fc)
    );

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .REFRESH_DIV(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb),
        .o_x(b_x), .o_y(b_y), .o_h_sync(b_hs), .o_v_sync(b_vs), .o_active(b_act),
        .o_frame_start(b_fs), .o_sprite_refresh(b_rf), .o_frame_cnt(b_fc)
    );

    display_timing_gen dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb),
        .o_x(c_x), .o_y(c_y), .o_h_sync(c_hs), .o_v_sync(c_vs), .o_active(c_act),
        .o_frame_start(c_fs), .o_sprite_refresh(c_rf), .o_frame_cnt(c_fc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic sync_exp(input int c, input int a, input int fp, input int sw,
                                      input logic pol);
        return (c >= a + fp && c < a + fp + sw) ? pol : ~pol;
    endfunction

    // Model: a linear pixel index within the frame, plus frames started since reset.
    int   p_s, frames_s, p_c;
    logic fs_s, fs_c;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s = 0; frames_s = 0; fs_s = 1'b0; p_c = 0; fs_c = 1'b0;
        end else if (stb) begin
            p_s  = (p_s + 1) % NS;
            fs_s = (p_s == 0);
            if (fs_s) frames_s++;
            p_c  = (p_c + 1) % (DHT * DVT);
            fs_c = (p_c == 0);
        end else begin
            fs_s = 1'b0;
            fs_c = 1'b0;
        end
    end

    always @(negedge clk) begin
        int sx, sy, cx, cy, efc;
        logic erf;
        sx = p_s % HT; sy = p_s / HT;
        cx = p_c % DHT; cy = p_c / DHT;
`ifdef REFRESH_DIVIDER_EN
        efc = frames_s % 4;
        erf = fs_s && (frames_s % 4 == 0);
`else
        efc = 0;
        erf = fs_s;
`endif
        chk("a_x", 32'(a_x), 32'(sx));
        chk("a_y", 32'(a_y), 32'(sy));
        chk("a_hsync", 32'(a_hs), 32'(sync_exp(sx, HA, HF, HS, 1'b1)));
        chk("a_vsync", 32'(a_vs), 32'(sync_exp(sy, VA, VF, VS, 1'b1)));
        chk("a_active", 32'(a_act), 32'(sx < HA && sy < VA));
        chk("a_frame_start", 32'(a_fs), 32'(fs_s));
        chk("a_refresh", 32'(a_rf), 32'(erf));
        chk("a_frame_cnt", 32'(a_fc), 32'(efc));
        chk("b_x", 32'(b_x), 32'(sx));
        chk("b_y", 32'(b_y), 32'(sy));
        chk("b_hsync", 32'(b_hs), 32'(sync_exp(sx, HA, HF, HS, 1'b0)));
        chk("b_vsync", 32'(b_vs), 32'(sync_exp(sy, VA, VF, VS, 1'b0)));
        chk("b_active", 32'(b_act), 32'(sx < HA && sy < VA));
        chk("b_frame_start", 32'(b_fs), 32'(fs_s));
        chk("b_refresh", 32'(b_rf), 32'(fs_s));
        chk("b_frame_cnt", 32'(b_fc), 32'd0);
        chk("c_x", 32'(c_x), 32'(cx));
        chk("c_y", 32'(c_y), 32'(cy));
        chk("c_hsync", 32'(c_hs), 32'(sync_exp(cx, 800, 40, 128, 1'b1)));
        chk("c_vsync", 32'(c_vs), 32'(sync_exp(cy, 600, 1, 4, 1'b1)));
        chk("c_active", 32'(c_act), 32'(cx < 800 && cy < 600));
        chk("c_frame_start", 32'(c_fs), 32'(fs_c));
    end

    initial begin
        // Reset held: literal reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_x", 32'(a_x), 32'd0);
        chk("rst_a_active", 32'(a_act), 32'd1);
        chk("rst_a_hsync", 32'(a_hs), 32'd0);
        chk("rst_b_hsync", 32'(b_hs), 32'd1);
        chk("rst_a_frame_start", 32'(a_fs), 32'd0);
        chk("rst_a_frame_cnt", 32'(a_fc), 32'd0);

        #1; rst_n = 1'b1; stb = 1'b1;
        // 840 strobes: default raster at x=840 (sync start), small raster at a wrap.
        repeat (840) @(posedge clk);
        #1;
        chk("lit_c_x840", 32'(c_x), 32'd840);
        chk("lit_c_hsync840", 32'(c_hs), 32'd1);
        chk("lit_a_x_wrap", 32'(a_x), 32'd0);
        chk("lit_a_y_wrap", 32'(a_y), 32'd0);
        chk("lit_a_frame_start", 32'(a_fs), 32'd1);
`ifdef REFRESH_DIVIDER_EN
        chk("lit_a_frame_cnt7", 32'(a_fc), 32'd3);
`else
        chk("lit_a_frame_cnt7", 32'(a_fc), 32'd0);
`endif
        repeat (127) @(posedge clk);
        #1;
        chk("lit_c_hsync967", 32'(c_hs), 32'd1);
        @(posedge clk);
        #1;
        chk("lit_c_x968", 32'(c_x), 32'd968);
        chk("lit_c_hsync968", 32'(c_hs), 32'd0);

        // Alternating strobe: wraps must land only on strobe edges.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2; stb = ~stb;
        end
        // Random strobe.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2; stb = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset mid-frame, between edges.
        stb = 1'b1;
        repeat (37) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("arst_a_x", 32'(a_x), 32'd0);
        chk("arst_a_y", 32'(a_y), 32'd0);
        chk("arst_a_active", 32'(a_act), 32'd1);
        chk("arst_a_hsync", 32'(a_hs), 32'd0);
        chk("arst_a_vsync", 32'(a_vs), 32'd0);
        chk("arst_a_frame_start", 32'(a_fs), 32'd0);
        chk("arst_a_refresh", 32'(a_rf), 32'd0);
        chk("arst_a_frame_cnt", 32'(a_fc), 32'd0);
        chk("arst_c_x", 32'(c_x), 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("restart_a_x", 32'(a_x), 32'd5);
        chk("restart_c_x", 32'(c_x), 32'd5);

        // Fourth frame start after reset: refresh fires, counter back to 0.
        repeat (475) @(posedge clk);
        #1;
        chk("lit_a_frame_start4", 32'(a_fs), 32'd1);
        chk("lit_a_refresh4", 32'(a_rf), 32'd1);
        chk("lit_a_frame_cnt4", 32'(a_fc), 32'd0);
        repeat (620) @(posedge clk);
        #2; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 The module SHALL expose these parameters, one per line: name, default, meaning.
- H_ACTIVE  800  visible pixels per line
- H_FP  40  horizontal front porch, in pixels
- H_SYNC  128  horizontal sync width, in pixels
- H_BP  88  horizontal back porch, in pixels
- V_ACTIVE  600  visible lines per frame
- V_FP  1  vertical front porch, in lines
- V_SYNC  4  vertical sync width, in lines
- V_BP  23  vertical back porch, in lines
- SYNC_POL  1  asserted level of both syncs (1 = positive)
- REFRESH_DIV  4  frames per o_sprite_refresh pulse, legal range 1..255

REQ-002 The module SHALL have these ports, one per line: name  direction  width  meaning.
- i_clk  in  1  single clock; all logic runs on its rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_pix_stb  in  1  pixel clock-enable; the counters advance only on cycles where it is high
- o_x  out  16  horizontal count, 0..H_TOTAL-1
- o_y  out  16  vertical count, 0..V_TOTAL-1
- o_h_sync  out  1  horizontal sync, level SYNC_POL
- o_v_sync  out  1  vertical sync, level SYNC_POL
- o_active  out  1  high when o_x<H_ACTIVE and o_y<V_ACTIVE
- o_frame_start  out  1  one-i_clk pulse when counters wrap to (0,0)
- o_sprite_refresh  out  1  one-i_clk pulse on selected frame starts; drives the game's sprite/object update tick
- o_frame_cnt  out  8  frame counter within the refresh period

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (1056 at default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (628 at default).
REQ-004 On each i_clk edge with i_pix_stb=1, o_x SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 and o_y SHALL increment.
REQ-005 o_y SHALL wrap from V_TOTAL-1 to 0 on the same edge that o_x wraps.
REQ-006 With i_pix_stb=0, every output SHALL hold its value, except the pulse outputs, which SHALL be 0.
REQ-007 o_h_sync SHALL be at level SYNC_POL exactly when H_ACTIVE+H_FP <= o_x < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL be at level ~SYNC_POL.
REQ-008 o_v_sync SHALL follow the same rule as REQ-007 using o_y, V_ACTIVE, V_FP and V_SYNC.
REQ-009 All outputs SHALL be registered; the syncs and o_active SHALL be computed from the next-state counts so they align with o_x/o_y in the same cycle, with zero cycles of skew.
REQ-010 o_frame_start SHALL be high for exactly the one i_clk cycle following the edge on which (o_x,o_y) became (0,0) through a wrap, never through reset.
REQ-011 o_frame_cnt SHALL increment on each o_frame_start; it SHALL wrap from REFRESH_DIV-1 to 0 and pulse o_sprite_refresh in that same cycle.
REQ-012 All counter arithmetic SHALL be unsigned; bits of o_x/o_y above the needed width SHALL read as 0.

Reset
REQ-013 Asserting i_rst_n low SHALL immediately and asynchronously set o_x=0, o_y=0, o_frame_cnt=0, o_frame_start=0, o_sprite_refresh=0, o_h_sync=~SYNC_POL, o_v_sync=~SYNC_POL and o_active=1.
REQ-014 Reset asserted mid-frame SHALL abandon the frame; no o_frame_start or o_sprite_refresh pulse SHALL be produced by the reset or its release.
REQ-015 After release, the first o_x increment SHALL occur on the first rising edge of i_clk with i_pix_stb=1.

Configuration
REQ-016 Macro REFRESH_DIVIDER_EN:
- Defined: the frame divider of REQ-011 is present.
- Undefined: o_sprite_refresh equals o_frame_start, o_frame_cnt is tied to 0, and REFRESH_DIV is ignored.

Verification
REQ-017 Defaults, i_pix_stb=1 for 2 frames: o_h_sync high for exactly x=840..967; o_v_sync high for exactly y=601..604; o_frame_start pulses once per 663168 cycles.
REQ-018 i_pix_stb toggling 1,0,1,0 with x=1055, y=627: wrap to (0,0) happens only on the strobe edge; o_frame_start pulses once, one cycle wide.
REQ-019 REFRESH_DIVIDER_EN defined, REFRESH_DIV=4, 9 frames: o_sprite_refresh pulses at frame starts 4 and 8; o_frame_cnt runs 1,2,3,0,1,2,3,0,1.
REQ-020 REFRESH_DIVIDER_EN undefined: o_sprite_refresh is identical to o_frame_start every frame; o_frame_cnt stays 0.
REQ-021 Assert i_rst_n low asynchronously at x=500, y=300: outputs take the REQ-013 values before the next edge; no pulse occurs; counting restarts from (0,0).
REQ-022 SYNC_POL=0: both syncs are inverted relative to REQ-017; o_active is high for exactly 800x600 positions per frame.
